// File: rtl/rv32i_pkg.sv
// Shared RV32I integer-core constants and the writeback-source encoding used
// by the register-file access controller.
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_rr_arb.sv
// Two-way round-robin arbiter for the shared register-file write port.
// After every grant the non-granted requester becomes the favoured one.
module wb_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;  // index of the requester that wins a tie

    // NOTE: every output of an always_comb gets a default first so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt[ptr] = 1'b1;
        end else begin
            gnt = req;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (|gnt) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Issue-side scoreboard and read sequencing for the register file, plus the
// shared write port fed by the ALU (wb0) and LSU (wb1) writeback streams.
module regfile_access_ctrl #(
    parameter int XLEN       = rv32i_pkg::XLEN,
    parameter int REG_ADDR_W = rv32i_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_rd_we,
    input  logic                  issue_wb_src,
    output logic                  opnd_valid,
    input  logic                  wb0_valid,
    output logic                  wb0_ready,
    input  logic [REG_ADDR_W-1:0] wb0_rd,
    input  logic [XLEN-1:0]       wb0_data,
    input  logic                  wb1_valid,
    output logic                  wb1_ready,
    input  logic [REG_ADDR_W-1:0] wb1_rd,
    input  logic [XLEN-1:0]       wb1_data,
    output logic [REG_ADDR_W-1:0] rf_rs_addr_1,
    output logic [REG_ADDR_W-1:0] rf_rs_addr_2,
    output logic                  rf_renable,
    output logic [REG_ADDR_W-1:0] rf_rd_addr,
    output logic [XLEN-1:0]       rf_rd_val,
    output logic                  rf_wenable,
    output logic [31:0]           busy_vec
);

    import rv32i_pkg::NUM_REGS;
    import rv32i_pkg::wb_src_e;
    import rv32i_pkg::WB_ALU;
    import rv32i_pkg::WB_LSU;

    logic [1:0]            gnt;
    logic                  wb_fire;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    wb_src_e               wb_src;

    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   src_tbl;
    logic [NUM_REGS-1:0]   clr_vec;
    logic [NUM_REGS-1:0]   set_vec;
    logic [NUM_REGS-1:0]   busy_eff;
    logic                  accept;

    wb_rr_arb u_arb (
        .clk (clk),
        .rst (rst),
        .req ({wb1_valid, wb0_valid}),
        .gnt (gnt)
    );

    assign wb0_ready = gnt[0];
    assign wb1_ready = gnt[1];
    assign wb_fire   = |gnt;

    always_comb begin
        wb_rd   = wb0_rd;
        wb_data = wb0_data;
        wb_src  = WB_ALU;
        if (gnt[1]) begin
            wb_rd   = wb1_rd;
            wb_data = wb1_data;
            wb_src  = WB_LSU;
        end
    end

    assign rf_rd_addr = wb_rd;
    assign rf_rd_val  = wb_data;
    assign rf_wenable = wb_fire && (wb_rd != '0) && !rst;

    // Only the source that owns the pending result may retire it; a stray
    // write from the other unit still lands in the regfile (WAW tolerated).
    always_comb begin
        clr_vec = '0;
        if (wb_fire && (wb_rd != '0) && (src_tbl[wb_rd] == wb_src)) begin
            clr_vec[wb_rd] = 1'b1;
        end
    end

    // Write and read-address capture share the edge, so a register retiring
    // this cycle already reads back the new value.
    assign busy_eff    = busy_q & ~clr_vec;
    assign issue_ready = !(busy_eff[issue_rs1] || busy_eff[issue_rs2] ||
                           (issue_rd_we && busy_eff[issue_rd]));

    assign accept       = issue_valid && issue_ready && !rst;
    assign rf_renable   = accept;
    assign rf_rs_addr_1 = issue_rs1;
    assign rf_rs_addr_2 = issue_rs2;

    always_comb begin
        set_vec = '0;
        if (accept && issue_rd_we && (issue_rd != '0)) begin
            set_vec[issue_rd] = 1'b1;
        end
    end

    // NOTE: the source table is small and its contents are observable after
    // reset, so it is reset like ordinary state rather than left as memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            src_tbl    <= '0;
            opnd_valid <= 1'b0;
        end else begin
            busy_q     <= busy_eff | set_vec;
            opnd_valid <= accept;
            if (|set_vec) begin
                src_tbl[issue_rd] <= issue_wb_src;
            end
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl: a per-cycle reference model of the
// scoreboard and arbiter plus hand-computed checks for the key scenarios.
module tb_regfile_access_ctrl;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue_valid, issue_ready;
    logic [AW-1:0]   issue_rs1, issue_rs2, issue_rd;
    logic            issue_rd_we, issue_wb_src;
    logic            opnd_valid;
    logic            wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [AW-1:0]   wb0_rd, wb1_rd;
    logic [XLEN-1:0] wb0_data, wb1_data;
    logic [AW-1:0]   rf_rs_addr_1, rf_rs_addr_2, rf_rd_addr;
    logic            rf_renable, rf_wenable;
    logic [XLEN-1:0] rf_rd_val;
    logic [31:0]     busy_vec;

    regfile_access_ctrl #(.XLEN(XLEN), .REG_ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_rd     (issue_rd),
        .issue_rd_we  (issue_rd_we),
        .issue_wb_src (issue_wb_src),
        .opnd_valid   (opnd_valid),
        .wb0_valid    (wb0_valid),
        .wb0_ready    (wb0_ready),
        .wb0_rd       (wb0_rd),
        .wb0_data     (wb0_data),
        .wb1_valid    (wb1_valid),
        .wb1_ready    (wb1_ready),
        .wb1_rd       (wb1_rd),
        .wb1_data     (wb1_data),
        .rf_rs_addr_1 (rf_rs_addr_1),
        .rf_rs_addr_2 (rf_rs_addr_2),
        .rf_renable   (rf_renable),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rd_val    (rf_rd_val),
        .rf_wenable   (rf_wenable),
        .busy_vec     (busy_vec)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: which registers await a result, and from where.
    bit [31:0] m_busy = '0;
    bit [31:0] m_src  = '0;
    int        m_ptr  = 0;
    bit        m_opnd = 1'b0;

    typedef struct {
        int              win;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        int              clr;
        bit              wen;
        bit              ready;
        bit              accept;
    } exp_t;

    function automatic bit held(input logic [AW-1:0] r, input int clr);
        return (r != 0) && m_busy[r] && (int'(r) != clr);
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e.win = -1;
        if (wb0_valid && wb1_valid) e.win = m_ptr;
        else if (wb0_valid)         e.win = 0;
        else if (wb1_valid)         e.win = 1;
        e.rd   = (e.win == 1) ? wb1_rd : wb0_rd;
        e.data = (e.win == 1) ? wb1_data : wb0_data;
        e.wen  = (e.win >= 0) && (e.rd != 0) && !rst;
        e.clr  = -1;
        if ((e.win >= 0) && (e.rd != 0) && m_busy[e.rd] && (m_src[e.rd] == (e.win == 1)))
            e.clr = int'(e.rd);
        e.ready  = !(held(issue_rs1, e.clr) || held(issue_rs2, e.clr) ||
                     (issue_rd_we && held(issue_rd, e.clr)));
        e.accept = issue_valid && e.ready && !rst;
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        exp_t e;
        if (rst) begin
            m_busy <= '0;
            m_src  <= '0;
            m_ptr  <= 0;
            m_opnd <= 1'b0;
        end else begin
            e = expect_now();
            m_opnd <= e.accept;
            if (e.accept && issue_rd_we && issue_rd != 0) begin
                m_busy       <= (e.clr >= 0 ? m_busy & ~(32'd1 << e.clr) : m_busy) | (32'd1 << issue_rd);
                m_src[issue_rd] <= issue_wb_src;
            end else if (e.clr >= 0) begin
                m_busy[e.clr] <= 1'b0;
            end
            if (e.win >= 0) m_ptr <= 1 - e.win;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        e = expect_now();
        check("m_busy_vec",    busy_vec,    m_busy);
        check("m_opnd_valid",  opnd_valid,  m_opnd);
        check("m_issue_ready", issue_ready, e.ready);
        check("m_rf_renable",  rf_renable,  e.accept);
        check("m_wb0_ready",   wb0_ready,   e.win == 0);
        check("m_wb1_ready",   wb1_ready,   e.win == 1);
        check("m_rf_wenable",  rf_wenable,  e.wen);
        if (e.accept) begin
            check("m_rs_addr_1", rf_rs_addr_1, issue_rs1);
            check("m_rs_addr_2", rf_rs_addr_2, issue_rs2);
        end
        if (e.win >= 0) begin
            check("m_rd_addr", rf_rd_addr, e.rd);
            check("m_rd_val",  rf_rd_val,  e.data);
        end
    end

    task automatic idle_inputs();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        issue_rd_we = 0; issue_wb_src = 0;
        wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
        wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy_vec, 0);
        check("rst_opnd", opnd_valid, 0);
        next_cycle();
        rst = 1'b0;

        // RAW stall on x5 until its ALU writeback is granted
        issue_valid = 1; issue_rd = 5; issue_rd_we = 1; issue_wb_src = 0;
        @(negedge clk); check("raw_first_ready", issue_ready, 1);
        next_cycle();
        issue_rd = 0; issue_rd_we = 0; issue_rs1 = 5;
        @(negedge clk);
        check("raw_stall_ready", issue_ready, 0);
        check("raw_busy5", busy_vec[5], 1);
        check("raw_opnd_first", opnd_valid, 1);
        next_cycle();
        @(negedge clk);
        check("raw_stall_ready2", issue_ready, 0);
        check("raw_opnd_stalled", opnd_valid, 0);
        next_cycle();
        wb0_valid = 1; wb0_rd = 5; wb0_data = 32'h55;
        @(negedge clk);
        check("raw_wb_ready", wb0_ready, 1);
        check("raw_release_ready", issue_ready, 1);
        check("raw_wen", rf_wenable, 1);
        check("raw_wval", rf_rd_val, 32'h55);
        check("raw_renable", rf_renable, 1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("raw_opnd_after", opnd_valid, 1);
        check("raw_busy_clear", busy_vec, 0);

        // lone wb1 grant returns the pointer to wb0, then alternate
        next_cycle();
        wb1_valid = 1; wb1_rd = 0;
        @(negedge clk); check("lone_wb1", wb1_ready, 1);
        next_cycle();
        wb0_valid = 1; wb1_valid = 1; wb0_rd = 1; wb1_rd = 2;
        for (int i = 0; i < 4; i++) begin
            wb0_data = 32'h100 + i;
            wb1_data = 32'h200 + i;
            @(negedge clk);
            check("rr_gnt0", wb0_ready, (i % 2) == 0);
            check("rr_val", rf_rd_val, ((i % 2) == 0) ? 32'h100 + i : 32'h200 + i);
            next_cycle();
        end
        idle_inputs();

        // writeback to x0 is accepted but never written
        wb0_valid = 1; wb0_rd = 0; wb0_data = 32'hDEAD;
        @(negedge clk);
        check("x0_ready", wb0_ready, 1);
        check("x0_wen", rf_wenable, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk); check("x0_busy", busy_vec, 0);

        // same-cycle set and clear of x7: set wins
        next_cycle();
        issue_valid = 1; issue_rd = 7; issue_rd_we = 1; issue_wb_src = 0;
        next_cycle();
        wb0_valid = 1; wb0_rd = 7; wb0_data = 32'd77;
        @(negedge clk);
        check("sc_ready", issue_ready, 1);
        check("sc_wb_ready", wb0_ready, 1);
        next_cycle();
        idle_inputs();
        @(negedge clk); check("sc_busy7", busy_vec, 32'h80);
        next_cycle();
        wb0_valid = 1; wb0_rd = 7;
        next_cycle();
        idle_inputs();
        @(negedge clk); check("sc_busy7_clear", busy_vec, 0);

        // x4 owned by LSU: ALU write lands but does not retire it
        issue_valid = 1; issue_rd = 4; issue_rd_we = 1; issue_wb_src = 1;
        next_cycle();
        issue_rd = 0; issue_rd_we = 0; issue_wb_src = 0; issue_rs1 = 4;
        wb0_valid = 1; wb0_rd = 4; wb0_data = 32'h44;
        @(negedge clk);
        check("waw_wen", rf_wenable, 1);
        check("waw_ready", issue_ready, 0);
        next_cycle();
        wb0_valid = 0; wb1_valid = 1; wb1_rd = 4; wb1_data = 32'h4444;
        @(negedge clk);
        check("waw_still_busy", busy_vec, 32'h10);
        check("waw_lsu_ready", issue_ready, 1);
        next_cycle();
        idle_inputs();
        @(negedge clk); check("waw_busy_clear", busy_vec, 0);

        // mid-cycle reset discards x3/x9
        issue_valid = 1; issue_rd = 3; issue_rd_we = 1;
        next_cycle();
        issue_rd = 9;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("pre_rst_busy", busy_vec, 32'h208);
        check("pre_rst_opnd", opnd_valid, 1);
        #2 rst = 1'b1;
        wb0_valid = 1; wb0_rd = 2; issue_valid = 1; issue_rs1 = 3;
        #1;
        check("rst_busy_async", busy_vec, 0);
        check("rst_opnd_async", opnd_valid, 0);
        check("rst_wen_gated", rf_wenable, 0);
        check("rst_ren_gated", rf_renable, 0);
        check("rst_wb_ready", wb0_ready, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        idle_inputs();
        next_cycle();
        issue_valid = 1; issue_rs1 = 3;
        wb1_valid = 1; wb1_rd = 9; wb1_data = 32'h99;
        @(negedge clk);
        check("post_rst_ready", issue_ready, 1);
        check("post_rst_ren", rf_renable, 1);
        check("post_rst_wen", rf_wenable, 1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("post_rst_busy", busy_vec, 0);
        check("post_rst_opnd", opnd_valid, 1);

        // all-zero register operands with write enable
        issue_valid = 1; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_rd_we = 1;
        @(negedge clk); check("zero_ready", issue_ready, 1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("zero_busy", busy_vec, 0);
        check("zero_opnd", opnd_valid, 1);

        repeat (2) next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register address width (32 architectural registers, x0 hardwired zero).
REQ-003 SHALL have ports, one per line:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  controller accepts it
- issue_rs1, issue_rs2  in  REG_ADDR_W  source registers
- issue_rd  in  REG_ADDR_W  destination register
- issue_rd_we  in  1  instruction will write issue_rd
- issue_wb_src  in  1  0 = ALU writes back, 1 = LSU writes back
- opnd_valid  out  1  regfile outputs hold operands of the last accepted issue
- wb0_valid/wb0_ready/wb0_rd/wb0_data  in/out/in/in  1/1/REG_ADDR_W/XLEN  ALU writeback
- wb1_valid/wb1_ready/wb1_rd/wb1_data  in/out/in/in  1/1/REG_ADDR_W/XLEN  LSU writeback
- rf_rs_addr_1, rf_rs_addr_2  out  REG_ADDR_W  to regfile read addresses
- rf_renable  out  1  to regfile read enable
- rf_rd_addr  out  REG_ADDR_W  to regfile write address
- rf_rd_val  out  XLEN  to regfile write data
- rf_wenable  out  1  to regfile write enable
- busy_vec  out  32  scoreboard, bit0 always 0

Function
REQ-004 Regfile write port SHALL be shared between wb0 and wb1 by 2-way round-robin. One grant per cycle; wbN_ready = grant to N.
REQ-005 Round-robin pointer SHALL move to the non-granted requester after every grant. It SHALL hold when there is no grant. A lone valid requester SHALL be granted regardless of the pointer.
REQ-006 rf_rd_addr, rf_rd_val and rf_wenable SHALL be combinational from the granted request. rf_wenable = grant AND rd != 0.
REQ-007 A writeback with rd = 0 SHALL be accepted (ready asserted) and SHALL cause no write.
REQ-008 busy_vec[r] SHALL be set at the edge where an issue is accepted with issue_rd_we = 1 and issue_rd = r != 0.
REQ-009 busy_vec[r] SHALL clear at the edge where a writeback to r is granted.
REQ-010 If a set and a clear of the same r occur in the same cycle, the set SHALL win (bit stays 1).
REQ-011 issue_ready SHALL be 0 while any of these is busy: rs1, rs2, or rd when issue_rd_we = 1. The check SHALL use busy bits after masking the same-cycle writeback clear. Justification: regfile write and read-address capture share the edge, so the read returns new data.
REQ-012 Register 0 SHALL never be busy.
REQ-013 On accepted issue, rf_renable SHALL be 1 and rf_rs_addr_1/2 = issue_rs1/2, combinational. rf_renable SHALL be 0 otherwise.
REQ-014 opnd_valid SHALL be a register. It is 1 exactly one cycle after an accepted issue and 0 otherwise. Read latency SHALL be 1 cycle.
REQ-015 issue_wb_src SHALL be recorded per busy register, in a 32x1 register. A writeback to a busy r from the other source SHALL NOT clear busy_vec[r]. It SHALL still be written (WAW tolerated, documented).
REQ-016 issue_ready SHALL NOT depend combinationally on issue_valid. wbN_ready SHALL NOT depend on any issue_* input.

Reset
REQ-017 On rst assertion, asynchronously: busy_vec = 0, source table = 0, RR pointer = wb0, opnd_valid = 0.
REQ-018 rst mid-operation SHALL discard all pending scoreboard state. Writebacks arriving after reset release SHALL be performed normally with no busy effect.
REQ-019 Combinational outputs during reset SHALL follow inputs. rf_wenable and rf_renable SHALL be gated to 0 while rst = 1.

Structure
REQ-020 XLEN, REG_ADDR_W, NUM_REGS = 32 and the wb source encoding (WB_ALU = 0, WB_LSU = 1) SHALL live in shared package rv32i_pkg.
REQ-021 The 2-way round-robin SHALL be sub-module wb_rr_arb (req[1:0], gnt[1:0], clk, rst). Scoreboard and read sequencing SHALL be in regfile_access_ctrl. Target size is 150-250 RTL lines.

Verification
REQ-022 Issue rd = 5, we = 1, src = ALU, then issue rs1 = 5 next cycle -> issue_ready = 0 until wb0 rd = 5 is granted. In that grant cycle issue_ready = 1 and opnd_valid = 1 the next cycle.
REQ-023 wb0 and wb1 valid continuously, pointer at wb0 -> grants alternate 0,1,0,1. rf_rd_val tracks the granted data.
REQ-024 wb0 rd = 0 data 0xDEAD -> wb0_ready = 1, rf_wenable = 0, busy_vec unchanged.
REQ-025 Same cycle: issue rd = 7 (ALU) accepted and wb0 rd = 7 granted, with 7 busy beforehand -> busy_vec[7] = 1 after the edge.
REQ-026 Set busy on regs 3 and 9, assert rst for 1 cycle mid-clock -> busy_vec = 0 immediately and opnd_valid = 0. An issue with rs1 = 3 is accepted the cycle after release.
REQ-027 Issue rs1 = 0, rs2 = 0, rd = 0, we = 1 -> accepted, busy_vec stays 0, opnd_valid = 1 one cycle later.
